// File: rtl/psg_pkg.sv
// Shared definitions for the PSG bus interface: bus mode codes, register
// addresses and the per-register storage mask.
package psg_pkg;

   localparam logic [1:0] MODE_INACTIVE = 2'b00;
   localparam logic [1:0] MODE_READ     = 2'b01;
   localparam logic [1:0] MODE_WRITE    = 2'b10;
   localparam logic [1:0] MODE_LATCH    = 2'b11;

   localparam int NUM_REGS = 14;

   localparam logic [3:0] R_TONE_A_FINE   = 4'd0;
   localparam logic [3:0] R_TONE_A_COARSE = 4'd1;
   localparam logic [3:0] R_TONE_B_FINE   = 4'd2;
   localparam logic [3:0] R_TONE_B_COARSE = 4'd3;
   localparam logic [3:0] R_TONE_C_FINE   = 4'd4;
   localparam logic [3:0] R_TONE_C_COARSE = 4'd5;
   localparam logic [3:0] R_NOISE_PERIOD  = 4'd6;
   localparam logic [3:0] R_MIXER         = 4'd7;
   localparam logic [3:0] R_AMP_A         = 4'd8;
   localparam logic [3:0] R_AMP_B         = 4'd9;
   localparam logic [3:0] R_AMP_C         = 4'd10;
   localparam logic [3:0] R_ENV_FINE      = 4'd11;
   localparam logic [3:0] R_ENV_COARSE    = 4'd12;
   localparam logic [3:0] R_ENV_SHAPE     = 4'd13;

   // Unimplemented high bits are never stored, so they always read back as 0.
   function automatic logic [7:0] reg_mask(input logic [3:0] a);
      case (a)
         R_TONE_A_COARSE, R_TONE_B_COARSE, R_TONE_C_COARSE, R_ENV_SHAPE: reg_mask = 8'h0F;
         R_NOISE_PERIOD, R_AMP_A, R_AMP_B, R_AMP_C:                      reg_mask = 8'h1F;
         default:                                                        reg_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/psg_bus_sync.sv
// Synchronizes the asynchronous BDIR/BC1/DA bus as one word and flags the
// first synchronized cycle of each new bus mode.
module psg_bus_sync
   import psg_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bdir,
   input  logic       bc1,
   input  logic [7:0] data_in,
   output logic [1:0] mode,
   output logic [7:0] data,
   output logic       mode_event
);

   logic [9:0] stage [SYNC_STAGES];
   logic [1:0] prev_mode;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= {MODE_INACTIVE, 8'h00};
         end
         prev_mode <= MODE_INACTIVE;
      end else begin
         stage[0] <= {bdir, bc1, data_in};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
         prev_mode <= mode;
      end
   end

   assign mode       = stage[SYNC_STAGES-1][9:8];
   assign data       = stage[SYNC_STAGES-1][7:0];
   assign mode_event = (mode != prev_mode);

endmodule

// File: rtl/psg_bus_interface.sv
// CPU-facing register file of the AY-3-8913-compatible PSG: address latch,
// chip select, 14 masked registers, read port and envelope restart pulse.
module psg_bus_interface
   import psg_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] CHIP_ADDR   = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bdir,
   input  logic        bc1,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_out_en,
   output logic [11:0] tone_period_a,
   output logic [11:0] tone_period_b,
   output logic [11:0] tone_period_c,
   output logic [4:0]  noise_period,
   output logic [2:0]  tone_disable,
   output logic [2:0]  noise_disable,
   output logic [4:0]  amplitude_a,
   output logic [4:0]  amplitude_b,
   output logic [4:0]  amplitude_c,
   output logic [15:0] envelope_period,
   output logic        continue_,
   output logic        attack,
   output logic        alternate,
   output logic        hold,
   output logic        envelope_restart
);

   logic [1:0] mode;
   logic [7:0] data;
   logic       mode_event;
   logic [7:0] regs [NUM_REGS];
   logic [3:0] addr;
   logic       selected;

   psg_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .reset      (reset),
      .bdir       (bdir),
      .bc1        (bc1),
      .data_in    (data_in),
      .mode       (mode),
      .data       (data),
      .mode_event (mode_event)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         addr             <= '0;
         selected         <= 1'b0;
         data_out         <= '0;
         data_out_en      <= 1'b0;
         envelope_restart <= 1'b0;
      end else begin
         envelope_restart <= 1'b0;
         if (mode_event && mode == MODE_LATCH) begin
            addr     <= data[3:0];
            selected <= (data[7:4] == CHIP_ADDR);
         end
         // Restart fires on every accepted R13 write, even if the value is unchanged.
         if (mode_event && mode == MODE_WRITE && selected && addr <= R_ENV_SHAPE) begin
            regs[addr]       <= data & reg_mask(addr);
            envelope_restart <= (addr == R_ENV_SHAPE);
         end
         if (mode == MODE_READ && selected) begin
            data_out    <= (addr <= R_ENV_SHAPE) ? regs[addr] : 8'h00;
            data_out_en <= 1'b1;
         end else begin
            data_out    <= '0;
            data_out_en <= 1'b0;
         end
      end
   end

   assign tone_period_a   = {regs[R_TONE_A_COARSE][3:0], regs[R_TONE_A_FINE]};
   assign tone_period_b   = {regs[R_TONE_B_COARSE][3:0], regs[R_TONE_B_FINE]};
   assign tone_period_c   = {regs[R_TONE_C_COARSE][3:0], regs[R_TONE_C_FINE]};
   assign noise_period    = regs[R_NOISE_PERIOD][4:0];
   assign tone_disable    = regs[R_MIXER][2:0];
   assign noise_disable   = regs[R_MIXER][5:3];
   assign amplitude_a     = regs[R_AMP_A][4:0];
   assign amplitude_b     = regs[R_AMP_B][4:0];
   assign amplitude_c     = regs[R_AMP_C][4:0];
   assign envelope_period = {regs[R_ENV_COARSE], regs[R_ENV_FINE]};
   assign continue_       = regs[R_ENV_SHAPE][3];
   assign attack          = regs[R_ENV_SHAPE][2];
   assign alternate       = regs[R_ENV_SHAPE][1];
   assign hold            = regs[R_ENV_SHAPE][0];

endmodule

// File: tb/tb_psg_bus_interface.sv
// Bench for psg_bus_interface: directed bus scenarios plus random bus traffic,
// checked every cycle against a delayed-sample register-file model.
module tb_psg_bus_interface;

   localparam int S = 3;
   localparam int H = S + 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bdir = 1'b0;
   logic        bc1 = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic        data_out_en;
   logic [11:0] tone_period_a, tone_period_b, tone_period_c;
   logic [4:0]  noise_period;
   logic [2:0]  tone_disable, noise_disable;
   logic [4:0]  amplitude_a, amplitude_b, amplitude_c;
   logic [15:0] envelope_period;
   logic        continue_, attack, alternate, hold, envelope_restart;

   always #5 clk = ~clk;

   psg_bus_interface #(
      .SYNC_STAGES (S),
      .CHIP_ADDR   (4'h0)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bdir             (bdir),
      .bc1              (bc1),
      .data_in          (data_in),
      .data_out         (data_out),
      .data_out_en      (data_out_en),
      .tone_period_a    (tone_period_a),
      .tone_period_b    (tone_period_b),
      .tone_period_c    (tone_period_c),
      .noise_period     (noise_period),
      .tone_disable     (tone_disable),
      .noise_disable    (noise_disable),
      .amplitude_a      (amplitude_a),
      .amplitude_b      (amplitude_b),
      .amplitude_c      (amplitude_c),
      .envelope_period  (envelope_period),
      .continue_        (continue_),
      .attack           (attack),
      .alternate        (alternate),
      .hold             (hold),
      .envelope_restart (envelope_restart)
   );

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   bit run = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: the logic sees the bus exactly S clock edges late; reset empties the delay.
   logic [9:0] q[$];
   logic [7:0] mreg [14];
   logic [3:0] maddr;
   logic       msel, mden, mrst;
   logic [1:0] mprev;
   logic [7:0] mdout;

   function automatic logic [7:0] mask(input int a);
      case (a)
         1, 3, 5, 13:  mask = 8'h0F;
         6, 8, 9, 10:  mask = 8'h1F;
         default:      mask = 8'hFF;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [9:0] view;
      logic       ev;
      if (reset) begin
         q.delete();
         repeat (S) q.push_back(10'h000);
         foreach (mreg[i]) mreg[i] = 8'h00;
         maddr = 4'h0; msel = 1'b0; mprev = 2'b00;
         mdout = 8'h00; mden = 1'b0; mrst = 1'b0;
      end else begin
         view = q.pop_front();
         q.push_back({bdir, bc1, data_in});
         ev    = (view[9:8] != mprev);
         mprev = view[9:8];
         mrst  = 1'b0;
         if (view[9:8] == 2'b01 && msel) begin
            mden  = 1'b1;
            mdout = (maddr < 14) ? mreg[maddr] : 8'h00;
         end else begin
            mden  = 1'b0;
            mdout = 8'h00;
         end
         if (ev && view[9:8] == 2'b11) begin
            maddr = view[3:0];
            msel  = (view[7:4] == 4'h0);
         end
         if (ev && view[9:8] == 2'b10 && msel && maddr < 14) begin
            mreg[maddr] = view[7:0] & mask(maddr);
            mrst        = (maddr == 13);
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("fields",
             {tone_period_a, tone_period_b, tone_period_c, noise_period, tone_disable,
              noise_disable, amplitude_a, amplitude_b, amplitude_c, envelope_period,
              continue_, attack, alternate, hold},
             {mreg[1][3:0], mreg[0], mreg[3][3:0], mreg[2], mreg[5][3:0], mreg[4],
              mreg[6][4:0], mreg[7][2:0], mreg[7][5:3], mreg[8][4:0], mreg[9][4:0],
              mreg[10][4:0], mreg[12], mreg[11], mreg[13][3], mreg[13][2], mreg[13][1],
              mreg[13][0]});
         chk("read", {data_out_en, data_out}, {mden, mdout});
         chk("restart", envelope_restart, mrst);
         if (envelope_restart) pulses++;
      end
   end

   task automatic drive(input logic [1:0] m, input logic [7:0] d, input int n);
      {bdir, bc1} = m;
      data_in = d;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lat(input logic [7:0] v);  drive(2'b11, v, H);    endtask
   task automatic wr(input logic [7:0] v);   drive(2'b10, v, H);    endtask
   task automatic rd();                      drive(2'b01, 8'h00, H); endtask
   task automatic idle(input int n);         drive(2'b00, 8'h00, n); endtask

   initial begin
      int p0;
      int op, n;
      logic [7:0] d;

      @(posedge clk);
      run = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      idle(H);

      // Every address reads 0 after reset; enable tracks READ only.
      for (int a = 0; a < 16; a++) begin
         lat(8'(a));
         rd();
         chk("rd_reset", {data_out_en, data_out}, 9'h100);
         idle(H);
         chk("rd_off", data_out_en, 1'b0);
      end
      chk("no_restart_yet", pulses, 0);

      // Tone A coarse/fine, masked readback.
      lat(8'h01); wr(8'hFF); idle(H);
      lat(8'h00); wr(8'h34); idle(H);
      chk("tone_a", tone_period_a, 12'hF34);
      lat(8'h01); rd();
      chk("rd_r1", {data_out_en, data_out}, 9'h10F);
      idle(H);

      // Envelope shape written twice with the same value: two restarts.
      p0 = pulses;
      lat(8'h0D); wr(8'h0E); idle(H);
      wr(8'h0E); idle(H);
      chk("shape", {continue_, attack, alternate, hold}, 4'b1110);
      chk("restart_count", pulses - p0, 2);

      // Wrong chip is ignored, then selected write lands.
      lat(8'h1B); wr(8'h55); idle(H);
      chk("unsel_wr", envelope_period[7:0], 8'h00);
      rd();
      chk("unsel_rd", {data_out_en, data_out}, 9'h000);
      idle(H);
      lat(8'h0B); wr(8'h55); idle(H);
      chk("env_fine", envelope_period[7:0], 8'h55);

      // Long held write with data changing mid-hold is a single event.
      lat(8'h08);
      drive(2'b10, 8'h1F, 25);
      drive(2'b10, 8'h00, 25);
      idle(H);
      chk("amp_a_hold", amplitude_a, 5'h1F);

      // Reset in the middle of a held write; the refilled WRITE arrives unselected.
      lat(8'h0C);
      drive(2'b10, 8'h77, 2);
      reset = 1'b1;
      drive(2'b10, 8'h77, 1);
      chk("reset_outs",
          {tone_period_a, tone_period_b, tone_period_c, noise_period, tone_disable,
           noise_disable, amplitude_a, amplitude_b, amplitude_c, envelope_period,
           continue_, attack, alternate, hold, data_out, data_out_en, envelope_restart},
          128'h0);
      drive(2'b10, 8'h77, 1);
      reset = 1'b0;
      drive(2'b10, 8'h77, S + 4);
      chk("post_reset_wr", envelope_period, 16'h0000);
      idle(H);
      lat(8'h0C); wr(8'h77); idle(H);
      chk("env_coarse", envelope_period[15:8], 8'h77);

      // Random bus traffic, including short glitches and occasional resets.
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         n  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, S) : $urandom_range(S + 1, S + 4);
         d  = 8'($urandom);
         case (op)
            0, 1, 2: begin
               if ($urandom_range(0, 3) != 0) d[7:4] = 4'h0;
               drive(2'b11, d, n);
            end
            3, 4, 5: drive(2'b10, d, n);
            6, 7:    drive(2'b01, d, n);
            8:       drive(2'b00, d, n);
            default: begin
               if ($urandom_range(0, 4) == 0) begin
                  reset = 1'b1;
                  drive(2'($urandom), d, $urandom_range(1, 2));
                  reset = 1'b0;
               end else begin
                  drive(2'b00, d, n);
               end
            end
         endcase
      end
      idle(H);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
